fifo_drop_ctrl: RTL and testbench

FIFO_DROP_CTRL -- requirements
Module: fifo_drop_ctrl

---
 rtl/fifo_drop_pkg.sv | 15 +
 rtl/counter_bin_load.sv | 51 +++++
 rtl/fifo_drop_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_drop_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_drop_pkg.sv
// Shared types for the FIFO pointer/drop controller.
// No logic; types and constants only.
// No flow control of its own.
package fifo_drop_pkg;

  // Drop sequencer states: accept in IDLE, adjust rd_ptr in DROP, report in DONE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DROP = 2'd1,
    DONE = 2'd2
  } drop_state_e;

  localparam int DEFAULT_DEPTH = 8;

endpackage : fifo_drop_pkg

// File: rtl/counter_bin_load.sv
// Wrap-bit binary pointer: +1 step, +N jump, or parallel load.
// Next value registered on the following clk edge.
// No flow control; priority is load > add > increment.
module counter_bin_load #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             add_enable,
  input  logic [WIDTH-1:0] add_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt
);

  localparam int LW = WIDTH - 1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next pointer value; MAX is a power of two and the range is 2*MAX, so the
  // +N jump wraps naturally in WIDTH bits while +1 toggles the MSB at MAX-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (add_enable) begin
      cnt_d = cnt_q + add_val;
    end else if (enable) begin
      if (cnt_q[LW-1:0] == LW'(MAX - 1)) begin
        cnt_d = {~cnt_q[LW], {LW{1'b0}}};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pointer register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : counter_bin_load

// File: rtl/fifo_drop_ctrl.sv
// FIFO pointer controller with a bulk drop of the oldest entries.
// Drop completes 2 cycles after acceptance (DROP, then DONE pulse).
// Writes and pops stall only during DROP; one drop in flight at a time.
module fifo_drop_ctrl
  import fifo_drop_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  input  logic          drop_req_valid,
  output logic          drop_req_ready,
  input  logic          drop_all,
  input  logic [AW:0]   drop_count,
  output logic          drop_done,
  output logic [AW:0]   drop_done_count,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  drop_state_e state_q;
  logic        drop_all_q;
  logic [AW:0] drop_cnt_q;
  logic        drop_done_q;
  logic [AW:0] drop_done_count_q;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] eff;
  logic        in_drop;
  logic        wr_fire;
  logic        rd_fire;
  logic        drop_fire;

  assign in_drop   = (state_q == DROP);
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ready       = ~full & ~in_drop;
  assign rd_valid       = ~empty & ~in_drop;
  assign drop_req_ready = (state_q == IDLE);

  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = rd_valid & rd_ready;
  assign drop_fire = drop_req_valid & drop_req_ready;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Entries to discard: occupancy is frozen in DROP, so clamp against it
  always_comb begin
    eff = count;
    if (!drop_all_q && (drop_cnt_q < count)) begin
      eff = drop_cnt_q;
    end
  end

  counter_bin_load #(
    .WIDTH (AW + 1),
    .MAX   (DEPTH)
  ) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (wr_fire),
    .add_enable (1'b0),
    .add_val    ('0),
    .load       (1'b0),
    .load_val   ('0),
    .cnt        (wr_ptr)
  );

  // Drop moves only the read side: jump forward by eff, or catch up to wr_ptr
  counter_bin_load #(
    .WIDTH (AW + 1),
    .MAX   (DEPTH)
  ) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (rd_fire),
    .add_enable (in_drop & ~drop_all_q),
    .add_val    (eff),
    .load       (in_drop & drop_all_q),
    .load_val   (wr_ptr),
    .cnt        (rd_ptr)
  );

  // Drop sequencer with registered completion outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      drop_all_q        <= 1'b0;
      drop_cnt_q        <= '0;
      drop_done_q       <= 1'b0;
      drop_done_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          drop_done_q       <= 1'b0;
          drop_done_count_q <= '0;
          if (drop_fire) begin
            drop_all_q <= drop_all;
            drop_cnt_q <= drop_count;
            state_q    <= DROP;
          end
        end
        DROP: begin
          drop_done_q       <= 1'b1;
          drop_done_count_q <= eff;
          state_q           <= DONE;
        end
        DONE: begin
          drop_done_q       <= 1'b0;
          drop_done_count_q <= '0;
          state_q           <= IDLE;
        end
        default: begin
          drop_done_q       <= 1'b0;
          drop_done_count_q <= '0;
          state_q           <= IDLE;
        end
      endcase
    end
  end

  assign drop_done       = drop_done_q;
  assign drop_done_count = drop_done_count_q;

endmodule : fifo_drop_ctrl

// File: tb/tb_fifo_drop_ctrl.sv
// Bench for fifo_drop_ctrl at DEPTH=8.
// Table of per-cycle vectors plus an address/drop scoreboard.
// Inputs driven after the edge, outputs sampled 1 time unit later.
module tb_fifo_drop_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          drop_req_valid, drop_req_ready, drop_all;
  logic [AW:0]   drop_count;
  logic          drop_done;
  logic [AW:0]   drop_done_count, count;
  logic          full, empty;

  always #5 clk = ~clk;

  fifo_drop_ctrl #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .drop_req_valid  (drop_req_valid),
    .drop_req_ready  (drop_req_ready),
    .drop_all        (drop_all),
    .drop_count      (drop_count),
    .drop_done       (drop_done),
    .drop_done_count (drop_done_count),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  typedef struct {
    bit wr; bit rd; bit drq; bit dall; int dcnt;
    int cnt; bit f; bit e; bit wrdy; bit rvld; bit drdy; bit done; int dc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   sb_addr[$];   // RAM addresses of stored entries, oldest first
  int   sb_eff[$];    // expected drop_done_count of pending drops
  int   wp = 0;       // model write pointer, 0..2*DEPTH-1

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input bit rd, input bit drq, input bit dall, input int dcnt,
                     input int cnt, input bit f, input bit e, input bit wrdy, input bit rvld,
                     input bit drdy, input bit done, input int dc);
    vec_t v;
    v.wr = wr; v.rd = rd; v.drq = drq; v.dall = dall; v.dcnt = dcnt;
    v.cnt = cnt; v.f = f; v.e = e; v.wrdy = wrdy; v.rvld = rvld;
    v.drdy = drdy; v.done = done; v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    bit    dfire;
    int    n, e;
    tag = $sformatf("v%0d", idx);
    wr_valid       = v.wr;
    rd_ready       = v.rd;
    drop_req_valid = v.drq;
    drop_all       = v.dall;
    drop_count     = 4'(v.dcnt);
    #1;
    chk({tag, ".count"},           count,           v.cnt);
    chk({tag, ".full"},            full,            int'(v.f));
    chk({tag, ".empty"},           empty,           int'(v.e));
    chk({tag, ".wr_ready"},        wr_ready,        int'(v.wrdy));
    chk({tag, ".rd_valid"},        rd_valid,        int'(v.rvld));
    chk({tag, ".drop_req_ready"},  drop_req_ready,  int'(v.drdy));
    chk({tag, ".drop_done"},       drop_done,       int'(v.done));
    chk({tag, ".drop_done_count"}, drop_done_count, v.dc);
    // Scoreboard: retire a finished drop before any pop in the same cycle
    if (drop_done === 1'b1) begin
      if (sb_eff.size() == 0) begin
        chk({tag, ".spurious_done"}, drop_done, 0);
      end else begin
        e = sb_eff.pop_front();
        chk({tag, ".sb_done_count"}, drop_done_count, e);
        repeat (e) if (sb_addr.size() > 0) void'(sb_addr.pop_front());
      end
    end
    if (rd_valid && rd_ready) begin
      if (sb_addr.size() == 0) chk({tag, ".pop_on_empty"}, rd_valid, 0);
      else chk({tag, ".rd_addr"}, rd_addr, sb_addr.pop_front());
    end
    if (wr_valid && wr_ready) begin
      chk({tag, ".wr_addr"}, wr_addr, wp % DEPTH);
      sb_addr.push_back(wp % DEPTH);
      wp = (wp + 1) % (2 * DEPTH);
    end
    dfire = drop_req_valid && drop_req_ready;
    @(posedge clk);
    #1;
    if (dfire) begin
      n = sb_addr.size();
      e = v.dall ? n : ((v.dcnt < n) ? v.dcnt : n);
      sb_eff.push_back(e);
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i], n_vec);
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    drop_req_valid = 1'b0; drop_all = 1'b0; drop_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, fill to full, refused write, drain, refused pop
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    for (int k = 0; k < 8; k++) add(1,0,0,0,0, k,0,(k==0),1,(k>0),1,0,0);
    add(1,0,0,0,0, 8,1,0,0,1,1,0,0);
    for (int k = 0; k < 8; k++) add(0,1,0,0,0, 8-k,(k==0),0,(k>0),1,1,0,0);
    add(0,1,0,0,0, 0,0,1,1,0,1,0,0);
    run_tbl();
    chk("rd_ptr_msb_after_fill_drain", dut.rd_ptr[AW], 1);

    // Partial drop of 3 from 5, pop at rd_addr advanced by 3, refill to 2
    for (int k = 0; k < 5; k++) add(1,0,0,0,0, k,0,(k==0),1,(k>0),1,0,0);
    add(0,0,1,0,3, 5,0,0,1,1,1,0,0);
    add(1,1,0,0,0, 5,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 2,0,0,1,1,0,1,3);
    add(0,1,0,0,0, 2,0,0,1,1,1,0,0);
    add(1,0,0,0,0, 1,0,0,1,1,1,0,0);
    // Saturating drop of 6 from 2; request during DONE is held off
    add(0,0,1,0,6, 2,0,0,1,1,1,0,0);
    add(0,0,0,0,0, 2,0,0,0,0,0,0,0);
    add(0,0,1,0,1, 0,0,1,1,0,0,1,2);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    // drop_all at full with the write pointer wrapped past the read pointer
    for (int k = 0; k < 8; k++) add(1,0,0,0,0, k,0,(k==0),1,(k>0),1,0,0);
    add(0,0,1,1,0, 8,1,0,0,1,1,0,0);
    add(0,0,0,0,0, 8,1,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,1,1,0,0,1,8);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    run_tbl();
    chk("rd_addr_after_drop_all", rd_addr, wp % DEPTH);

    // Drop accepted together with a write and a pop at count 4; then a zero drop
    for (int k = 0; k < 4; k++) add(1,0,0,0,0, k,0,(k==0),1,(k>0),1,0,0);
    add(1,1,1,0,4, 4,0,0,1,1,1,0,0);
    add(0,0,0,0,0, 4,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,1,1,0,0,1,4);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    add(0,0,1,0,0, 0,0,1,1,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,1,1,0,0,1,0);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    // Setup for reset during DROP
    for (int k = 0; k < 3; k++) add(1,0,0,0,0, k,0,(k==0),1,(k>0),1,0,0);
    add(0,0,1,0,2, 3,0,0,1,1,1,0,0);
    run_tbl();

    // Now in DROP: reset abandons the drop without a completion pulse
    chk("in_drop_req_ready", drop_req_ready, 0);
    wr_valid = 1'b0; rd_ready = 1'b0; drop_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_addr.delete();
    sb_eff.delete();
    wp = 0;
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,1,0,1,0,0);
    run_tbl();
    chk("pending_drops_left", sb_eff.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fifo_drop_ctrl
